multicycle_controller: RTL and testbench

Parametrised multi-cycle successor to the single-cycle instruction decoder for the 16-bit SIMPLE core. It sequences each instruction through fetch/decode/execute/memory/writeback states and holds handshakes with instruction and data memories that may stall. It adds a latched SZCV flag register for conditional branches, halt/resume, a memory-ack timeout and a retired-instruction counter. It sits between the datapath and the memory ports, replacing the combinational control decode.

---
 rtl/ctrl_pkg.sv | 67 ++++++
 rtl/multicycle_controller_if.sv | 22 ++
 rtl/instr_decode.sv | 39 +++
 rtl/multicycle_controller.sv | 155 +++++++++++++++
 tb/tb_multicycle_controller.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the SIMPLE multi-cycle controller:
// FSM states, instruction field constants, flag bit positions and decode classes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    localparam logic [1:0] OP1_LD  = 2'b00;
    localparam logic [1:0] OP1_ST  = 2'b01;
    localparam logic [1:0] OP1_IMM = 2'b10;
    localparam logic [1:0] OP1_ALU = 2'b11;

    localparam logic [2:0] OP2_LI   = 3'b000;
    localparam logic [2:0] OP2_ADDI = 3'b001;
    localparam logic [2:0] OP2_B    = 3'b100;
    localparam logic [2:0] OP2_BCC  = 3'b111;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;

    localparam logic [3:0] OP3_CMP = 4'b0101;
    localparam logic [3:0] OP3_IN  = 4'b1100;
    localparam logic [3:0] OP3_OUT = 4'b1101;
    localparam logic [3:0] OP3_NOP = 4'b1110;
    localparam logic [3:0] OP3_HLT = 4'b1111;

    // Positions inside the {S,Z,C,V} flag vector.
    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic       is_ld;
        logic       is_st;
        logic       is_addi;
        logic       is_b;
        logic       is_bcc;
        logic       is_alu_flags;
        logic       is_out;
        logic       is_hlt;
        logic       writes_reg;
        logic [2:0] cond;
    } instr_class_t;

    function automatic logic branch_taken(input logic [2:0] cond, input logic s,
                                          input logic z, input logic v);
        case (cond)
            COND_BE:  return z;
            COND_BLT: return s ^ v;
            COND_BLE: return z | (s ^ v);
            COND_BNE: return ~z;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction/data memory handshake bundle between the controller and the memories.
// Handshake: the requester raises req and holds it (with dmem_we stable) until the
// cycle the responder answers with ack; the transfer happens in that cycle, and an
// ack seen while req is low carries no meaning and is ignored.
interface multicycle_controller_if;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] instr;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ack, instr, dmem_ack
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ack, instr, dmem_ack
    );
endinterface

// File: rtl/instr_decode.sv
// Pure combinational classification of an IR word into the instruction classes
// the sequencer branches on.
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [15:0]  ir,
    output instr_class_t cls
);
    logic [1:0] op1;
    logic [2:0] op2;
    logic [3:0] op3;
    logic       is_alu;
    logic       alu_quiet;
    logic       unused_lsb;

    assign op1        = ir[15:14];
    assign op2        = ir[13:11];
    assign op3        = ir[7:4];
    assign unused_lsb = ^ir[3:0];

    always_comb begin
        is_alu    = (op1 == OP1_ALU);
        // OUT/NOP/HLT neither touch the flags nor write a register.
        alu_quiet = (op3 == OP3_OUT) || (op3 == OP3_NOP) || (op3 == OP3_HLT);

        cls.is_ld        = (op1 == OP1_LD);
        cls.is_st        = (op1 == OP1_ST);
        cls.is_addi      = (op1 == OP1_IMM) && (op2 == OP2_ADDI);
        cls.is_b         = (op1 == OP1_IMM) && (op2 == OP2_B);
        cls.is_bcc       = (op1 == OP1_IMM) && (op2 == OP2_BCC);
        cls.is_alu_flags = is_alu && !alu_quiet;
        cls.is_out       = is_alu && (op3 == OP3_OUT);
        cls.is_hlt       = is_alu && (op3 == OP3_HLT);
        cls.writes_reg   = cls.is_ld
                         || ((op1 == OP1_IMM) && ((op2 == OP2_LI) || (op2 == OP2_ADDI)))
                         || (cls.is_alu_flags && (op3 != OP3_CMP));
        cls.cond         = ir[10:8];
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the 16-bit SIMPLE core: FSM, IR, latched SZCV flags,
// memory-ack timeout and retired-instruction counter.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT  = 255,
    parameter int TMO_W    = 8,
    parameter int RETIRE_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic [3:0]              flags_in,
    multicycle_controller_if.master mem,
    output logic                    ir_we,
    output logic                    pc_we,
    output logic                    pc_src,
    output logic                    reg_we,
    output logic                    mem_to_reg,
    output logic                    reg_dst,
    output logic                    alu_src,
    output logic                    flags_we,
    output logic                    out_we,
    output logic                    halted,
    output logic                    err,
    output logic [RETIRE_W-1:0]     retired,
    output logic [2:0]              state
);
    state_t          state_q, state_d;
    logic [15:0]     ir_q;
    logic [3:0]      flag_q;
    logic [TMO_W-1:0] tmo_q;
    instr_class_t    dec;
    logic            imem_req, dmem_req, dmem_we;
    logic            retire, waiting, timed_out;
    logic            unused_c;

    instr_decode u_decode (.ir(ir_q), .cls(dec));

    assign mem.imem_req = imem_req;
    assign mem.dmem_req = dmem_req;
    assign mem.dmem_we  = dmem_we;
    assign state        = state_q;
    assign unused_c     = flag_q[FLAG_C];

    assign waiting   = (imem_req && !mem.imem_ack) || (dmem_req && !mem.dmem_ack);
    // Checked only in a cycle without ack, so a last-moment ack still wins.
    assign timed_out = (tmo_q == TMO_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            flag_q  <= '0;
            tmo_q   <= '0;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (ir_we)    ir_q   <= mem.instr;
            if (flags_we) flag_q <= flags_in;
            if (waiting)  tmo_q  <= tmo_q + TMO_W'(1);
            else          tmo_q  <= '0;
            if (retire)   retired <= retired + RETIRE_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        flags_we   = 1'b0;
        out_we     = 1'b0;
        halted     = 1'b0;
        err        = 1'b0;
        retire     = 1'b0;

        case (state_q)
            ST_IDLE: if (run) state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (mem.imem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (timed_out) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DECODE: begin
                if (dec.is_hlt) begin
                    retire  = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (dec.is_ld || dec.is_st) begin
                    alu_src = 1'b1;
                    state_d = ST_MEM;
                end else if (dec.writes_reg) begin
                    alu_src  = dec.is_addi;
                    flags_we = dec.is_alu_flags;
                    state_d  = ST_WB;
                end else begin
                    // CMP, OUT, NOP and branches all finish here; Bcc sees the latched flags.
                    flags_we = dec.is_alu_flags;
                    out_we   = dec.is_out;
                    if (dec.is_b || (dec.is_bcc &&
                        branch_taken(dec.cond, flag_q[FLAG_S], flag_q[FLAG_Z], flag_q[FLAG_V]))) begin
                        pc_we  = 1'b1;
                        pc_src = 1'b1;
                    end
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec.is_st;
                if (mem.dmem_ack) begin
                    if (dec.is_ld) begin
                        state_d = ST_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else if (timed_out) begin
                    state_d = ST_ERROR;
                end
            end
            ST_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = dec.is_ld;
                reg_dst    = !dec.is_ld;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (run) state_d = ST_FETCH;
            end
            ST_ERROR: err = 1'b1;
            default:  state_d = ST_ERROR;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-by-cycle directed vectors for multicycle_controller: instruction mix,
// stalls, branches on latched flags, halt/resume, timeout and reset mid-request.
module tb_multicycle_controller;
    localparam int RW = 4;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_ERR = 3'd7;

    // Control word: {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we,
    //                mem_to_reg, reg_dst, alu_src, flags_we, out_we, halted, err}
    localparam logic [13:0] IREQ = 14'h2000, DREQ = 14'h1000, DWE = 14'h0800, IRWE = 14'h0400;
    localparam logic [13:0] PCWE = 14'h0200, PCSRC = 14'h0100, REGWE = 14'h0080, M2R = 14'h0040;
    localparam logic [13:0] RDST = 14'h0020, ASRC = 14'h0010, FLWE = 14'h0008, OUTWE = 14'h0004;
    localparam logic [13:0] HLTD = 14'h0002, ERR = 14'h0001;
    localparam logic [13:0] FET = IREQ | IRWE | PCWE;

    typedef struct {
        logic          rst_n;
        logic          run;
        logic          imem_ack;
        logic          dmem_ack;
        logic [15:0]   instr;
        logic [3:0]    flags_in;
        logic [2:0]    exp_state;
        logic [13:0]   exp_ctrl;
        logic [RW-1:0] exp_retired;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n, run;
    logic [3:0]    flags_in;
    logic          ir_we, pc_we, pc_src, reg_we, mem_to_reg, reg_dst, alu_src;
    logic          flags_we, out_we, halted, err;
    logic [RW-1:0] retired;
    logic [2:0]    state;

    multicycle_controller_if bus ();

    multicycle_controller #(.TIMEOUT(4), .TMO_W(3), .RETIRE_W(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .flags_in   (flags_in),
        .mem        (bus.master),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .reg_we     (reg_we),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .alu_src    (alu_src),
        .flags_we   (flags_we),
        .out_we     (out_we),
        .halted     (halted),
        .err        (err),
        .retired    (retired),
        .state      (state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int   errors = 0;
    int   checks = 0;
    int   vec_idx = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at step %0d: got 0x%0h expected 0x%0h", name, vec_idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rn, input logic r, input logic ia, input logic da,
                                input logic [15:0] ins, input logic [3:0] fl,
                                input logic [2:0] st, input logic [13:0] c,
                                input logic [RW-1:0] ret);
        vec_t v;
        v.rst_n = rn; v.run = r; v.imem_ack = ia; v.dmem_ack = da;
        v.instr = ins; v.flags_in = fl;
        v.exp_state = st; v.exp_ctrl = c; v.exp_retired = ret;
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input vec_t v);
        logic [13:0] ctrl;
        @(negedge clk);
        rst_n        = v.rst_n;
        run          = v.run;
        bus.imem_ack = v.imem_ack;
        bus.dmem_ack = v.dmem_ack;
        bus.instr    = v.instr;
        flags_in     = v.flags_in;
        #1;
        ctrl = {bus.imem_req, bus.dmem_req, bus.dmem_we, ir_we, pc_we, pc_src, reg_we,
                mem_to_reg, reg_dst, alu_src, flags_we, out_we, halted, err};
        check("state", 32'(state), 32'(v.exp_state));
        check("ctrl", 32'(ctrl), 32'(v.exp_ctrl));
        check("retired", 32'(retired), 32'(v.exp_retired));
        vec_idx++;
    endtask

    // Zero-wait fetch of one instruction followed by its DECODE cycle.
    function automatic void fd(input logic [15:0] ins, input logic [RW-1:0] ret);
        vecs.push_back(mk(1, 0, 1, 0, ins, 4'h0, S_FETCH, FET, ret));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0, 4'h0, S_DEC, 14'h0, ret));
    endfunction

    function automatic void ex(input logic [3:0] fl, input logic [2:0] st,
                               input logic [13:0] c, input logic [RW-1:0] ret);
        vecs.push_back(mk(1, 0, 0, 0, 16'h0, fl, st, c, ret));
    endfunction

    initial begin
        rst_n = 1'b0; run = 1'b0; flags_in = 4'h0;
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.instr = 16'h0;
        @(posedge clk);

        // ---- table: reset, then a mixed instruction stream ----
        vecs.push_back(mk(0, 0, 0, 0, 16'h0, 4'h0, S_IDLE, 14'h0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'h0, 4'h0, S_IDLE, 14'h0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 16'hC000, 4'h0, S_FETCH, FET, 0));   // ADD
        vecs.push_back(mk(1, 1, 0, 1, 16'h0, 4'h0, S_DEC, 14'h0, 0));      // stray run/ack
        vecs.push_back(mk(1, 0, 1, 0, 16'h0, 4'h0, S_EXEC, FLWE, 0));
        ex(4'h0, S_WB, REGWE | RDST, 0);
        fd(16'h0000, 1);                                                    // LD, 3-cycle stall
        ex(4'h0, S_EXEC, ASRC, 1);
        ex(4'h0, S_MEM, DREQ, 1);
        ex(4'h0, S_MEM, DREQ, 1);
        ex(4'h0, S_MEM, DREQ, 1);
        vecs.push_back(mk(1, 0, 0, 1, 16'h0, 4'h0, S_MEM, DREQ, 1));
        ex(4'h0, S_WB, REGWE | M2R, 1);
        fd(16'hC050, 2); ex(4'h4, S_EXEC, FLWE, 2);                         // CMP Z=1
        fd(16'hB800, 3); ex(4'h0, S_EXEC, PCWE | PCSRC, 3);                 // BE taken
        fd(16'hC050, 4); ex(4'h0, S_EXEC, FLWE, 4);                         // CMP Z=0
        fd(16'hB800, 5); ex(4'h4, S_EXEC, 14'h0, 5);                        // BE not taken
        fd(16'h4000, 6); ex(4'h0, S_EXEC, ASRC, 6);                         // ST
        vecs.push_back(mk(1, 0, 0, 1, 16'h0, 4'h0, S_MEM, DREQ | DWE, 6));
        fd(16'h8800, 7); ex(4'h0, S_EXEC, ASRC, 7); ex(4'h0, S_WB, REGWE | RDST, 7);   // ADDI
        fd(16'hC0D0, 8); ex(4'h0, S_EXEC, OUTWE, 8);                        // OUT
        fd(16'h8000, 9); ex(4'h0, S_EXEC, 14'h0, 9); ex(4'h0, S_WB, REGWE | RDST, 9);  // LI
        fd(16'hA000, 10); ex(4'h0, S_EXEC, PCWE | PCSRC, 10);               // B
        fd(16'hC050, 11); ex(4'h9, S_EXEC, FLWE, 11);                       // CMP S=1 V=1
        fd(16'hBA00, 12); ex(4'h0, S_EXEC, 14'h0, 12);                      // BLE not taken
        fd(16'hC050, 13); ex(4'h8, S_EXEC, FLWE, 13);                       // CMP S=1
        fd(16'hB900, 14); ex(4'h0, S_EXEC, PCWE | PCSRC, 14);               // BLT taken
        vecs.push_back(mk(1, 0, 0, 0, 16'h0, 4'h0, S_FETCH, IREQ, 15));     // HLT, 1 stall
        fd(16'hC0F0, 15);
        ex(4'h0, S_HALT, HLTD, 0);                                          // 16 wraps to 0

        foreach (vecs[i]) step(vecs[i]);

        // ---- halt held 10 cycles, resume keeps flags and counting ----
        for (int i = 0; i < 9; i++) step(mk(1, 0, 0, 0, 16'h0, 4'h0, S_HALT, HLTD, 0));
        step(mk(1, 1, 0, 0, 16'h0, 4'h0, S_HALT, HLTD, 0));
        step(mk(1, 0, 1, 0, 16'hB900, 4'h0, S_FETCH, FET, 0));
        step(mk(1, 0, 0, 0, 16'h0, 4'h0, S_DEC, 14'h0, 0));
        step(mk(1, 0, 0, 0, 16'h0, 4'h0, S_EXEC, PCWE | PCSRC, 0));
        step(mk(1, 0, 1, 0, 16'hC0E0, 4'h0, S_FETCH, FET, 1));              // NOP
        step(mk(1, 0, 0, 0, 16'h0, 4'h0, S_DEC, 14'h0, 1));
        step(mk(1, 0, 0, 0, 16'h0, 4'h0, S_EXEC, 14'h0, 1));

        // ---- fetch timeout: ack never comes ----
        for (int i = 0; i < 5; i++) step(mk(1, 0, 0, 0, 16'h0, 4'h0, S_FETCH, IREQ, 2));
        step(mk(1, 1, 1, 0, 16'h0, 4'h0, S_ERR, ERR, 2));
        step(mk(1, 1, 0, 0, 16'h0, 4'h0, S_ERR, ERR, 2));
        step(mk(0, 0, 0, 0, 16'h0, 4'h0, S_ERR, ERR, 2));

        // ---- ack arriving on the last allowed cycle wins ----
        step(mk(1, 1, 0, 0, 16'h0, 4'h0, S_IDLE, 14'h0, 0));
        for (int i = 0; i < 4; i++) step(mk(1, 0, 0, 0, 16'h0, 4'h0, S_FETCH, IREQ, 0));
        step(mk(1, 0, 1, 0, 16'hC0E0, 4'h0, S_FETCH, FET, 0));
        step(mk(1, 0, 0, 0, 16'h0, 4'h0, S_DEC, 14'h0, 0));
        step(mk(1, 0, 0, 0, 16'h0, 4'h0, S_EXEC, 14'h0, 0));

        // ---- reset while a load waits for dmem_ack ----
        step(mk(1, 0, 1, 0, 16'h0000, 4'h0, S_FETCH, FET, 1));
        step(mk(1, 0, 0, 0, 16'h0, 4'h0, S_DEC, 14'h0, 1));
        step(mk(1, 0, 0, 0, 16'h0, 4'h0, S_EXEC, ASRC, 1));
        step(mk(1, 0, 0, 0, 16'h0, 4'h0, S_MEM, DREQ, 1));
        step(mk(0, 0, 0, 0, 16'h0, 4'h0, S_MEM, DREQ, 1));
        step(mk(1, 0, 0, 1, 16'h0, 4'h0, S_IDLE, 14'h0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
